mem_addr_sequencer: RTL

//  Upstream driver for the 16x8 RAM/register-file display stage.

---
 rtl/mem_addr_sequencer_pkg.sv | 16 +
 rtl/key_edge_sync.sv | 59 +++++
 rtl/mem_addr_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_addr_sequencer_pkg.sv
// Shared definitions for the RAM/register-file address sequencer.
// Holds the FSM state encoding and the default address and data widths.
package mem_addr_sequencer_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int LAST_ADDR  = 2**ADDR_W_DEF - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2,
        SCAN = 2'd3
    } seq_state_t;

endpackage

// File: rtl/key_edge_sync.sv
// Synchronises a raw key, optionally debounces it (KEY_DEBOUNCE_EN), and emits a 1-cycle rising-edge pulse.
// The debounce stage is present only when KEY_DEBOUNCE_EN is defined.
module key_edge_sync #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic evt
);

    logic sync_p0;
    logic sync_p1;
    logic level;
    logic level_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= key;
            sync_p1 <= sync_p0;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    logic [CNT_W-1:0] stable_cnt;

    // The accepted level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_p1 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            level      <= sync_p1;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end
`else
    assign level = sync_p1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            evt     <= 1'b0;
        end else begin
            level_q <= level;
            evt     <= level & ~level_q;
        end
    end

endmodule

// File: rtl/mem_addr_sequencer.sv
// Address/data/write-enable driver for the 16x8 RAM display stage: manual step, bulk fill and timed scan.
// Define KEY_DEBOUNCE_EN to debounce the step key before edge detection.
module mem_addr_sequencer
    import mem_addr_sequencer_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int SCAN_DIV     = 25_000_000,
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step_key,
    input  logic              fill_req,
    input  logic              scan_en,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [ADDR_W-1:0] LAST  = {ADDR_W{1'b1}};

    seq_state_t        state;
    seq_state_t        next_state;
    logic              step_evt;
    logic [CNT_W-1:0]  scan_cnt;
    logic [DATA_W-1:0] seed_q;
    logic [ADDR_W-1:0] addr_inc;
    logic              scan_tick;

    assign addr_inc  = addr + ADDR_W'(1);
    assign scan_tick = (scan_cnt == CNT_W'(SCAN_DIV - 1));

    key_edge_sync #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_step_key (
        .clock(clock),
        .reset(reset),
        .key  (step_key),
        .evt  (step_evt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (fill_req)     next_state = FILL;
                else if (scan_en) next_state = SCAN;
            end
            FILL:    if (addr == LAST) next_state = DONE;
            DONE:    next_state = scan_en ? SCAN : IDLE;
            SCAN: begin
                if (fill_req)      next_state = FILL;
                else if (!scan_en) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they belong to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr     <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            scan_cnt <= '0;
            seed_q   <= '0;
        end else begin
            wr_en    <= (next_state == FILL);
            busy     <= (next_state == FILL) || (next_state == SCAN);
            done     <= (next_state == DONE);
            scan_cnt <= '0;
            case (next_state)
                FILL: begin
                    if (state == FILL) begin
                        addr    <= addr_inc;
                        wr_data <= seed_q + DATA_W'(addr_inc);
                    end else begin
                        addr    <= '0;
                        seed_q  <= seed;
                        wr_data <= seed;
                    end
                end
                DONE: addr <= '0;
                SCAN: begin
                    if (state == SCAN) begin
                        if (scan_tick) addr     <= addr_inc;
                        else           scan_cnt <= scan_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (state == IDLE && step_evt) addr <= addr_inc;
                end
            endcase
        end
    end

endmodule
